snake_head_tracker: RTL and testbench
=====================================

Name: snake_head_tracker

Overview:
Parametrised next-generation snake-head position tracker for an arbitrary GRID_W x GRID_H playfield. Latches the direction from the l/r/u/d buttons, with reversal rejection, and advances the head one cell per step strobe from the game-tick divider. Detects wall hits, or wraps around at the walls when WRAP_EN is defined. Feeds head_x/head_y to the body shift store and the display mapper; the game controller reads state and edge_collision.

Parameters:
GRID_W, 8, playfield width in cells (2..256)
GRID_H, 8, playfield height in cells (2..256)
XW, 3, width of x coordinate; must satisfy 2**XW >= GRID_W
YW, 3, width of y coordinate; must satisfy 2**YW >= GRID_H
START_X, 3, head x after reset (< GRID_W)
START_Y, 3, head y after reset (< GRID_H)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
step  in  1  one-cycle move strobe from tick divider
l  in  1  left button (level)
r  in  1  right button (level)
u  in  1  up button (level)
d  in  1  down button (level)
load  in  1  synchronous load of head position
load_x  in  XW  x value for load
load_y  in  YW  y value for load
head_x  out  XW  current head x
head_y  out  YW  current head y
dir  out  2  current direction: 00 right, 01 left, 10 up, 11 down
state  out  2  00 IDLE, 01 RUN, 10 DEAD
moved  out  1  one-cycle pulse after each accepted move
edge_collision  out  1  sticky wall-hit flag

Behaviour:
- Clocking: all state changes on posedge clk; no asynchronous paths. Priority order: reset > load > direction/step.
- Reset values: head_x=START_X, head_y=START_Y, dir=00, state=IDLE, moved=0, edge_collision=0.
- Button decode: at most one request per cycle. Priority is l > r > u > d. No button pressed means no request.
- IDLE:
  - Head holds; step is ignored.
  - Any button request sets dir to the requested direction and moves to RUN on the next cycle. No move happens in that cycle.
- RUN, direction:
  - A request that is the exact opposite of dir (L vs R, U vs D) is ignored.
  - Any other request updates dir in the same edge.
  - If a request and step occur in the same cycle, the new dir applies to that step.
- RUN, step=1 move:
  - right: x+1; left: x-1; up: y+1; down: y-1.
  - Compute in XW+1 / YW+1 bits.
  - Out of range means x<0, x>=GRID_W, y<0 or y>=GRID_H (the -1 case is caught by the borrow bit).
- RUN, in-range result: head updated at the step edge and visible the next cycle. moved=1 for exactly that next cycle.
- RUN, out-of-range result (WRAP_EN undefined):
  - Head holds its last legal cell.
  - edge_collision=1; state=DEAD.
  - moved stays 0.
- DEAD: step and buttons are ignored. edge_collision holds 1 until reset or load.
- load=1 (any state):
  - head_x = min(load_x, GRID_W-1); head_y = min(load_y, GRID_H-1).
  - edge_collision=0; state=IDLE; dir unchanged; moved=0.
  - step and buttons in the same cycle are ignored.
- Reset mid-move: a reset asserted with step overrides it; no moved pulse is produced.
- Non-power-of-two grids: x=GRID_W-1 moving right is out of range even though XW bits could represent it.

Optional Feature:
WRAP_EN
- Defined:
  - An out-of-range move wraps: right from GRID_W-1 goes to 0; left from 0 goes to GRID_W-1; likewise for y.
  - The wrapped move counts as a normal move (moved pulses).
  - edge_collision is tied to 0 and DEAD is unreachable through wall hits; it remains reachable only by encoding.
- Undefined: wall-hit behaviour as described in Behaviour.

Test Plan:
- Reset with defaults, then 3 cycles idle with step=1 -> head (3,3), state IDLE, dir 00, moved never 1.
- Press r, then 4 step pulses (GRID 8x8, WRAP_EN undefined) -> head x 4,5,6,7 with moved after each step. The 5th step gives state DEAD, edge_collision=1, head stays (7,3).
- RUN heading right, press l and step in the same cycle -> reversal ignored, head x+1, dir stays 00. Then press u with step -> y+1, dir 10.
- DEAD, load with load_x=5, load_y=6 -> head (5,6), edge_collision 0, state IDLE. A simultaneous step has no effect.
- GRID_W=5, XW=3, head x=4, dir right, step -> DEAD. With WRAP_EN defined, the same step gives x=0, moved=1, edge_collision=0.
- Load with load_x=7 on GRID_W=5 -> head_x saturates to 4. Then down steps from y=0 -> DEAD, or y=GRID_H-1 with WRAP_EN.

Source files
------------

// File: rtl/snake_head_tracker.sv
// Snake head position tracker: latches direction from l/r/u/d, advances one cell per step, flags or wraps at walls (WRAP_EN).
// Latency: head/dir/state update on the step or button edge; moved pulses in the following cycle.
// Backpressure: none; step and buttons are sampled every cycle and ignored outside RUN/IDLE as applicable.
module snake_head_tracker #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int XW      = 3,
    parameter int YW      = 3,
    parameter int START_X = 3,
    parameter int START_Y = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          l,
    input  logic          r,
    input  logic          u,
    input  logic          d,
    input  logic          load,
    input  logic [XW-1:0] load_x,
    input  logic [YW-1:0] load_y,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    dir,
    output logic [1:0]    state,
    output logic          moved,
    output logic          edge_collision
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_L = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    localparam logic [XW:0]   GRID_W_C = (XW+1)'(GRID_W);
    localparam logic [YW:0]   GRID_H_C = (YW+1)'(GRID_H);
    localparam logic [XW:0]   X_ONE    = (XW+1)'(1);
    localparam logic [YW:0]   Y_ONE    = (YW+1)'(1);
    localparam logic [XW-1:0] MAX_X    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] MAX_Y    = YW'(GRID_H - 1);

    state_t        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic          moved_q, moved_d;

    logic          req_vld;
    logic [1:0]    req_dir;
    logic [1:0]    opp_dir;
    logic [1:0]    run_dir;
    logic [XW:0]   x_ext, x_step;
    logic [YW:0]   y_ext, y_step;
    logic          x_oob, y_oob;

    // Button decode with fixed priority l > r > u > d
    always_comb begin
        req_vld = l | r | u | d;
        req_dir = DIR_D;
        if (l)
            req_dir = DIR_L;
        else if (r)
            req_dir = DIR_R;
        else if (u)
            req_dir = DIR_U;
    end

    // Opposite directions differ only in bit 0 with this encoding
    assign opp_dir = {dir_q[1], ~dir_q[0]};
    assign run_dir = (req_vld && (req_dir != opp_dir)) ? req_dir : dir_q;

    // One extra bit so that 0-1 shows up as a large value caught by the range test
    always_comb begin
        x_ext  = {1'b0, head_x_q};
        y_ext  = {1'b0, head_y_q};
        x_step = x_ext;
        y_step = y_ext;
        case (run_dir)
            DIR_R:   x_step = x_ext + X_ONE;
            DIR_L:   x_step = x_ext - X_ONE;
            DIR_U:   y_step = y_ext + Y_ONE;
            default: y_step = y_ext - Y_ONE;
        endcase
        x_oob = x_step[XW] | (x_step >= GRID_W_C);
        y_oob = y_step[YW] | (y_step >= GRID_H_C);
    end

`ifdef WRAP_EN
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        moved_d  = 1'b0;
        if (load) begin
            head_x_d = ({1'b0, load_x} >= GRID_W_C) ? MAX_X : load_x;
            head_y_d = ({1'b0, load_y} >= GRID_H_C) ? MAX_Y : load_y;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_vld) begin
                        dir_d   = req_dir;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    dir_d = run_dir;
                    if (step) begin
                        moved_d = 1'b1;
                        if (x_oob)
                            head_x_d = (run_dir == DIR_R) ? '0 : MAX_X;
                        else
                            head_x_d = x_step[XW-1:0];
                        if (y_oob)
                            head_y_d = (run_dir == DIR_U) ? '0 : MAX_Y;
                        else
                            head_y_d = y_step[YW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign edge_collision = 1'b0;
`else
    logic edge_q, edge_d;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        moved_d  = 1'b0;
        edge_d   = edge_q;
        if (load) begin
            head_x_d = ({1'b0, load_x} >= GRID_W_C) ? MAX_X : load_x;
            head_y_d = ({1'b0, load_y} >= GRID_H_C) ? MAX_Y : load_y;
            state_d  = ST_IDLE;
            edge_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_vld) begin
                        dir_d   = req_dir;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    dir_d = run_dir;
                    if (step) begin
                        if (x_oob || y_oob) begin
                            // Head stays on its last legal cell
                            edge_d  = 1'b1;
                            state_d = ST_DEAD;
                        end else begin
                            head_x_d = x_step[XW-1:0];
                            head_y_d = y_step[YW-1:0];
                            moved_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            edge_q <= 1'b0;
        else
            edge_q <= edge_d;
    end

    assign edge_collision = edge_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_R;
            head_x_q <= XW'(START_X);
            head_y_q <= YW'(START_Y);
            moved_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            moved_q  <= moved_d;
        end
    end

    assign head_x = head_x_q;
    assign head_y = head_y_q;
    assign dir    = dir_q;
    assign state  = state_q;
    assign moved  = moved_q;

endmodule

// File: tb/tb_snake_head_tracker.sv
// Bench for snake_head_tracker: an 8x8 and a 5x5 instance share stimulus; a cycle model feeds per-instance expectation queues.
module tb_snake_head_tracker;

    logic       clk = 1'b0;
    logic       reset, step, l, r, u, d, load;
    logic [2:0] load_x, load_y;

    logic [2:0] a_head_x, a_head_y, b_head_x, b_head_y;
    logic [1:0] a_dir, a_state, b_dir, b_state;
    logic       a_moved, a_edge, b_moved, b_edge;

`ifdef WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int dir;
        int st;
        int moved;
        int ec;
    } mdl_t;

    mdl_t ma, mb;
    mdl_t qa[$];
    mdl_t qb[$];
    int checks = 0;
    int errors = 0;

    snake_head_tracker u_a (
        .clk(clk), .reset(reset), .step(step), .l(l), .r(r), .u(u), .d(d),
        .load(load), .load_x(load_x), .load_y(load_y),
        .head_x(a_head_x), .head_y(a_head_y), .dir(a_dir), .state(a_state),
        .moved(a_moved), .edge_collision(a_edge)
    );

    snake_head_tracker #(
        .GRID_W(5), .GRID_H(5), .XW(3), .YW(3), .START_X(3), .START_Y(3)
    ) u_b (
        .clk(clk), .reset(reset), .step(step), .l(l), .r(r), .u(u), .d(d),
        .load(load), .load_x(load_x), .load_y(load_y),
        .head_x(b_head_x), .head_y(b_head_y), .dir(b_dir), .state(b_state),
        .moved(b_moved), .edge_collision(b_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int opposite(input int dr);
        case (dr)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic mdl_t model(input mdl_t m, input int gw, input int gh);
        mdl_t n;
        int   rq, tx, ty;
        n       = m;
        n.moved = 0;
        rq      = l ? 1 : r ? 0 : u ? 2 : d ? 3 : -1;
        if (reset) begin
            n.x = 3; n.y = 3; n.dir = 0; n.st = 0; n.ec = 0;
        end else if (load) begin
            n.x  = (int'(load_x) > gw - 1) ? gw - 1 : int'(load_x);
            n.y  = (int'(load_y) > gh - 1) ? gh - 1 : int'(load_y);
            n.st = 0;
            n.ec = 0;
        end else if (m.st == 0) begin
            if (rq >= 0) begin
                n.dir = rq;
                n.st  = 1;
            end
        end else if (m.st == 1) begin
            if (rq >= 0 && rq != opposite(m.dir))
                n.dir = rq;
            if (step) begin
                tx = m.x;
                ty = m.y;
                case (n.dir)
                    0:       tx = tx + 1;
                    1:       tx = tx - 1;
                    2:       ty = ty + 1;
                    default: ty = ty - 1;
                endcase
                if (tx < 0 || tx >= gw || ty < 0 || ty >= gh) begin
                    if (WRAP) begin
                        n.x = (tx + gw) % gw;
                        n.y = (ty + gh) % gh;
                        n.moved = 1;
                    end else begin
                        n.st = 2;
                        n.ec = 1;
                    end
                end else begin
                    n.x = tx;
                    n.y = ty;
                    n.moved = 1;
                end
            end
        end
        return n;
    endfunction

    task automatic cyc(input bit rs, input bit ld, input int lx, input int ly,
                       input bit st, input logic [3:0] lrud);
        mdl_t ea, eb;
        reset = rs; load = ld; step = st;
        load_x = 3'(lx); load_y = 3'(ly);
        {l, r, u, d} = lrud;
        ma = model(ma, 8, 8);
        mb = model(mb, 5, 5);
        qa.push_back(ma);
        qb.push_back(mb);
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_x", 32'(a_head_x), ea.x);
        check("a_y", 32'(a_head_y), ea.y);
        check("a_dir", 32'(a_dir), ea.dir);
        check("a_state", 32'(a_state), ea.st);
        check("a_moved", 32'(a_moved), ea.moved);
        check("a_edge", 32'(a_edge), ea.ec);
        check("b_x", 32'(b_head_x), eb.x);
        check("b_y", 32'(b_head_y), eb.y);
        check("b_dir", 32'(b_dir), eb.dir);
        check("b_state", 32'(b_state), eb.st);
        check("b_moved", 32'(b_moved), eb.moved);
        check("b_edge", 32'(b_edge), eb.ec);
    endtask

    localparam logic [3:0] NB = 4'b0000;
    localparam logic [3:0] BL = 4'b1000;
    localparam logic [3:0] BR = 4'b0100;
    localparam logic [3:0] BU = 4'b0010;
    localparam logic [3:0] BD = 4'b0001;

    initial begin
        ma = '{0, 0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0, 0};
        reset = 1'b1; load = 1'b0; step = 1'b0; l = 1'b0; r = 1'b0; u = 1'b0; d = 1'b0;
        load_x = '0; load_y = '0;

        // Reset (with step held), then idle steps are ignored
        repeat (2) cyc(1, 0, 0, 0, 1, NB);
        check("rst_x", 32'(a_head_x), 3);
        check("rst_y", 32'(a_head_y), 3);
        repeat (3) cyc(0, 0, 0, 0, 1, NB);

        // Start heading right and walk to the wall
        cyc(0, 0, 0, 0, 0, BR);
        repeat (4) begin
            cyc(0, 0, 0, 0, 1, NB);
            cyc(0, 0, 0, 0, 0, NB);
        end
        check("a_wall_x", 32'(a_head_x), 7);
        cyc(0, 0, 0, 0, 1, NB);
        check("a_hit_state", 32'(a_state), WRAP ? 1 : 2);
        check("a_hit_x", 32'(a_head_x), WRAP ? 0 : 7);
        repeat (2) cyc(0, 0, 0, 0, 1, BU);

        // Load out of DEAD with a simultaneous step and button
        cyc(0, 1, 5, 6, 1, BR);
        check("a_load_x", 32'(a_head_x), 5);
        check("a_load_y", 32'(a_head_y), 6);
        check("b_load_x", 32'(b_head_x), 4);

        // Reversal rejected with step, then a turn applied to the same step
        cyc(0, 0, 0, 0, 0, BR);
        cyc(0, 0, 0, 0, 1, BL);
        check("a_rev_x", 32'(a_head_x), 6);
        check("a_rev_dir", 32'(a_dir), 0);
        cyc(0, 0, 0, 0, 1, BU);
        check("a_turn_y", 32'(a_head_y), 7);
        check("a_turn_dir", 32'(a_dir), 2);
        cyc(0, 0, 0, 0, 1, NB);

        // Saturating load, then down off the bottom edge
        cyc(0, 1, 7, 0, 0, NB);
        check("b_sat_x", 32'(b_head_x), 4);
        cyc(0, 0, 0, 0, 0, BD);
        cyc(0, 0, 0, 0, 1, NB);
        check("b_down_y", 32'(b_head_y), WRAP ? 4 : 0);
        check("b_down_edge", 32'(b_edge), 0 + (WRAP ? 0 : 1));

        // Left off the left edge, and reset landing on a step
        cyc(0, 1, 0, 1, 0, NB);
        cyc(0, 0, 0, 0, 0, BL);
        cyc(0, 0, 0, 0, 1, NB);
        cyc(0, 1, 2, 2, 0, NB);
        cyc(0, 0, 0, 0, 0, BR);
        cyc(1, 0, 0, 0, 1, BR);
        cyc(0, 0, 0, 0, 0, NB);

        // Random traffic against the model
        repeat (400) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : NB);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
